apb_req_bridge: RTL
===================

// Module: apb_req_bridge
// PURPOSE
//  Single-outstanding bridge from the core/peripheral-interconnect req/gnt/r_valid port to an APB3 master port.
//  Sits directly upstream of the APB node and drives its slave port.
//  Each granted request becomes one APB SETUP+ACCESS transfer.
//  The completion is returned as a one-cycle r_valid pulse carrying read data and an error flag.
// PARAMETERS
//  APB_ADDR_WIDTH  32  width of addr_i / paddr_o
//  APB_DATA_WIDTH  32  width of wdata_i, r_rdata_o, pwdata_o, prdata_i
//  TIMEOUT_CYCLES  256 ACCESS-phase cycle limit; used only with APB_REQ_BRIDGE_TIMEOUT_EN; must be >= 2
// PORTS
//  clk_i      in  1    clock, all state on rising edge
//  rst_i      in  1    synchronous, active-high reset
//  req_i      in  1    request valid
//  gnt_o      out 1    request accepted this cycle (combinational)
//  addr_i     in  AW   byte address
//  we_i       in  1    1=write 0=read
//  wdata_i    in  DW   write data
//  r_valid_o  out 1    response pulse, exactly one per grant
//  r_rdata_o  out DW   read data, valid with r_valid_o
//  r_err_o    out 1    pslverr (or timeout) flag, valid with r_valid_o
//  paddr_o    out AW   APB address
//  pwdata_o   out DW   APB write data
//  pwrite_o   out 1    APB direction
//  psel_o     out 1    APB select
//  penable_o  out 1    APB enable
//  prdata_i   in  DW   APB read data
//  pready_i   in  1    APB ready
//  pslverr_i  in  1    APB slave error
// BEHAVIOUR
//  - FSM states: IDLE, SETUP, ACCESS.
//  - Reset: state=IDLE. All registered outputs are 0 (psel, penable, pwrite, paddr, pwdata, r_valid, r_rdata, r_err).
//  - gnt_o = req_i & (state==IDLE). It is never asserted outside IDLE.
//  - Grant edge: capture addr_i, we_i, wdata_i into paddr_o/pwrite_o/pwdata_o. These stay stable until the next grant. Next state is SETUP.
//  - SETUP (1 cycle): psel_o=1, penable_o=0. Next state is ACCESS unconditionally.
//  - ACCESS: psel_o=1, penable_o=1. Stay while pready_i=0.
//  - When pready_i=1 in ACCESS:
//    - r_valid_o=1 on the next cycle (registered).
//    - r_rdata_o = we ? 0 : prdata_i.
//    - r_err_o = pslverr_i.
//    - psel/penable drop to 0 and state returns to IDLE.
//  - Timing: pready sampled only in ACCESS. pslverr and prdata are ignored outside ACCESS.
//  - r_valid_o is high for exactly one cycle. r_rdata_o and r_err_o clear to 0 in cycles where r_valid_o is low.
//  - Back-to-back: a new req may be granted in the same cycle r_valid_o is high.
//  - Minimum request period is 3 cycles (grant, SETUP, ACCESS with pready).
//  - Latency: grant at cycle 0 -> r_valid at cycle 3 + N, where N = ACCESS wait cycles.
//  - Reset mid-transfer: abort immediately. psel/penable go to 0 on the reset edge and no r_valid is produced for the aborted request.
//  - No buffering: a req held while busy is granted on the first IDLE cycle. addr/we/wdata must be held stable until gnt_o.
// CONFIGURATION
//  - APB_REQ_BRIDGE_TIMEOUT_EN defined:
//    - Counter cleared on entry to ACCESS, incremented each ACCESS cycle with pready_i=0.
//    - When it reaches TIMEOUT_CYCLES-1 and pready_i=0: end the transfer as if pready=1, with r_err_o=1 and r_rdata_o=0, and return to IDLE.
//    - If pready_i=1 in the timeout cycle, pready wins and the normal response is returned.
//  - Not defined: no counter logic. ACCESS waits indefinitely for pready_i.
// STRUCTURE
//  - apb_req_bridge_pkg holds:
//    - typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_br_state_e
//    - localparam TO_CNT_W = $clog2(TIMEOUT_CYCLES)+1
//  - One sub-module, apb_req_bridge_timer: the timeout counter, instantiated only under the macro.
//  - The FSM and datapath stay in the top module.
// TESTING
//  - Zero-wait read:
//    - Stimulus: req addr=0x1A10_0004 we=0, pready=1 on first ACCESS cycle, prdata=0xCAFE_0001.
//    - Response: gnt c0, psel c1-c2, penable c2, r_valid c3 with rdata=0xCAFE_0001 and err=0.
//  - Write with 3 wait states:
//    - Stimulus: addr=0x1A10_2000 wdata=0x0000_00FF.
//    - Response: paddr/pwdata/pwrite stable through ACCESS, r_valid at c6, rdata=0, err=0.
//  - Slave error:
//    - Stimulus: read with pslverr=1 alongside pready.
//    - Response: r_err=1 for 1 cycle, then r_err=0.
//  - Back-to-back:
//    - Stimulus: req held high for 3 requests, all zero-wait.
//    - Response: grants at c0, c3, c6, r_valid pulses at c3, c6, c9, no overlap of psel phases.
//  - Reset mid-transfer:
//    - Stimulus: rst_i=1 in the second ACCESS wait cycle.
//    - Response: psel=penable=0 next cycle, no r_valid, a new req is granted right after reset deasserts.
//  - Timeout (macro on, TIMEOUT_CYCLES=4):
//    - Stimulus: pready held 0.
//    - Response: r_valid with err=1 and rdata=0 after 4 ACCESS cycles.
//    - Variant: pready=1 exactly in the 4th cycle -> err=0 and valid data returned.

Source files
------------

// File: rtl/apb_req_bridge_pkg.sv
// Shared types and sizing helpers for the req/gnt to APB3 bridge.
// The optional ACCESS-phase timeout is enabled by defining APB_REQ_BRIDGE_TIMEOUT_EN.
package apb_req_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_br_state_e;

  localparam int APB_ADDR_WIDTH_DFLT = 32;
  localparam int APB_DATA_WIDTH_DFLT = 32;
  localparam int TIMEOUT_CYCLES_DFLT = 256;

  // One spare bit so the terminal count TIMEOUT_CYCLES-1 always fits.
  function automatic int to_cnt_w(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

  localparam int TO_CNT_W = to_cnt_w(TIMEOUT_CYCLES_DFLT);

endpackage

// File: rtl/apb_req_bridge_if.sv
// Bundle of the core-side req/gnt/r_valid port and the APB3 master port.
// master = bridge view, slave = the core and APB node around it.
interface apb_req_bridge_if
  import apb_req_bridge_pkg::*;
#(
  parameter int AW = APB_ADDR_WIDTH_DFLT,
  parameter int DW = APB_DATA_WIDTH_DFLT
);

  logic          req_i;
  logic          gnt_o;
  logic [AW-1:0] addr_i;
  logic          we_i;
  logic [DW-1:0] wdata_i;
  logic          r_valid_o;
  logic [DW-1:0] r_rdata_o;
  logic          r_err_o;

  logic [AW-1:0] paddr_o;
  logic [DW-1:0] pwdata_o;
  logic          pwrite_o;
  logic          psel_o;
  logic          penable_o;
  logic [DW-1:0] prdata_i;
  logic          pready_i;
  logic          pslverr_i;

  modport master (
    input  req_i, addr_i, we_i, wdata_i, prdata_i, pready_i, pslverr_i,
    output gnt_o, r_valid_o, r_rdata_o, r_err_o,
           paddr_o, pwdata_o, pwrite_o, psel_o, penable_o
  );

  modport slave (
    output req_i, addr_i, we_i, wdata_i, prdata_i, pready_i, pslverr_i,
    input  gnt_o, r_valid_o, r_rdata_o, r_err_o,
           paddr_o, pwdata_o, pwrite_o, psel_o, penable_o
  );

endinterface

// File: rtl/apb_req_bridge_timer.sv
// ACCESS-phase wait counter; only instantiated when APB_REQ_BRIDGE_TIMEOUT_EN is defined.
// o_expired flags the cycle in which the count has reached TIMEOUT_CYCLES-1.
module apb_req_bridge_timer
  import apb_req_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expired
);

  localparam int CNT_W = to_cnt_w(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // Saturates at LIMIT; the bridge leaves ACCESS in that cycle anyway.
  always_ff @(posedge clk_i) begin
    if (rst_i || i_clear) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == LIMIT);

endmodule

// File: rtl/apb_req_bridge.sv
// Single-outstanding bridge: one granted req becomes one APB SETUP+ACCESS transfer.
// Define APB_REQ_BRIDGE_TIMEOUT_EN to bound the ACCESS phase at TIMEOUT_CYCLES cycles.
module apb_req_bridge
  import apb_req_bridge_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = APB_ADDR_WIDTH_DFLT,
  parameter int APB_DATA_WIDTH = APB_DATA_WIDTH_DFLT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  apb_req_bridge_if.master  bus
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("apb_req_bridge: TIMEOUT_CYCLES must be >= 2");
  end

  apb_br_state_e             r_state;
  logic                      r_psel;
  logic                      r_penable;
  logic                      r_pwrite;
  logic [APB_ADDR_WIDTH-1:0] r_paddr;
  logic [APB_DATA_WIDTH-1:0] r_pwdata;
  logic                      r_rvalid;
  logic [APB_DATA_WIDTH-1:0] r_rdata;
  logic                      r_err;

  logic w_gnt;
  logic w_timeout;
  logic w_done;

  assign w_gnt = bus.req_i && (r_state == IDLE);

`ifdef APB_REQ_BRIDGE_TIMEOUT_EN
  logic w_expired;

  apb_req_bridge_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_clear   (r_state == SETUP),
    .i_inc     ((r_state == ACCESS) && !bus.pready_i),
    .o_expired (w_expired)
  );

  // pready in the terminal cycle wins over the timeout.
  assign w_timeout = (r_state == ACCESS) && !bus.pready_i && w_expired;
`else
  assign w_timeout = 1'b0;
`endif

  assign w_done = (r_state == ACCESS) && (bus.pready_i || w_timeout);

  // NOTE: all state here updates with non-blocking assignments so every
  // branch sees the pre-edge values, regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      // Response fields are a one-cycle pulse, zero otherwise.
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt) begin
            r_paddr   <= bus.addr_i;
            r_pwrite  <= bus.we_i;
            r_pwdata  <= bus.wdata_i;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_state   <= SETUP;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          if (w_done) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_rvalid  <= 1'b1;
            r_state   <= IDLE;
            if (bus.pready_i) begin
              r_rdata <= r_pwrite ? '0 : bus.prdata_i;
              r_err   <= bus.pslverr_i;
            end else begin
              r_err   <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt_o     = w_gnt;
  assign bus.paddr_o   = r_paddr;
  assign bus.pwdata_o  = r_pwdata;
  assign bus.pwrite_o  = r_pwrite;
  assign bus.psel_o    = r_psel;
  assign bus.penable_o = r_penable;
  assign bus.r_valid_o = r_rvalid;
  assign bus.r_rdata_o = r_rdata;
  assign bus.r_err_o   = r_err;

endmodule
